// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus counter-based debounce FSM for one asynchronous input.
// Optional registered rise/fall pulses are built only when DEBOUNCE_SYNC_PULSE_EN is defined.
module debounce_sync #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer stage: only s2 is allowed to reach the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // Debounce stage: any sample matching q during CHECK is a bounce and aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s2 != q) begin
            state <= CHECK;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        CHECK: begin
          if (s2 == q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            q     <= s2;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == CHECK);

`ifdef DEBOUNCE_SYNC_PULSE_EN
  logic rise_r;
  logic fall_r;

  // Edge-pulse stage: fires on the same edge that commits q.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= (state == CHECK) && (s2 != q) && (cnt == CNT_MAX) &&  s2;
      fall_r <= (state == CHECK) && (s2 != q) && (cnt == CNT_MAX) && !s2;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule
